// File: rtl/enc_feeder_if.sv
// enc_feeder_if: handshake and data bundle between the message source, the
// feeder and the RS encoder data input.
//   master : source/encoder side (drives flush, in_valid, in_data, enc_stall)
//   slave  : enc_feeder (drives in_ready, data_out, out_valid, out_sof, level)
// W  = word width (ENC_SYM_NUM*EGF_ORDER), LW = $clog2(FIFO_DEPTH+1).
interface enc_feeder_if #(
   parameter int W  = 128,
   parameter int LW = 3
);
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_data;
   logic          enc_stall;
   logic [W-1:0]  data_out;
   logic          out_valid;
   logic          out_sof;
   logic [LW-1:0] level;

   modport master (
      output flush, in_valid, in_data, enc_stall,
      input  in_ready, data_out, out_valid, out_sof, level
   );

   modport slave (
      input  flush, in_valid, in_data, enc_stall,
      output in_ready, data_out, out_valid, out_sof, level
   );
endinterface

// File: rtl/enc_feeder.sv
// enc_feeder: upstream stage of the RS encoder. Buffers source message words
// in a small FIFO and presents one word per cycle to the encoder data input,
// holding while the encoder stalls. Tracks the word position inside a
// codeword and flags word 0 with out_sof.
//
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : enc_feeder_if.slave (flush, in_valid/in_ready/in_data,
//            enc_stall, data_out/out_valid/out_sof, level)
//
// Build option: define ENC_FEEDER_BYPASS_EN to let a word arriving at an
// empty FIFO go straight to data_out on the accepting edge.
module enc_feeder #(
   parameter int EGF_ORDER   = 8,
   parameter int ENC_SYM_NUM = 16,
   parameter int FIFO_DEPTH  = 4,
   parameter int MSG_WORDS   = 15
) (
   input logic        clk,
   input logic        rst_n,
   enc_feeder_if.slave bus
);
   localparam int W  = ENC_SYM_NUM * EGF_ORDER;
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int LW = $clog2(FIFO_DEPTH + 1);
   localparam int SW = (MSG_WORDS > 1) ? $clog2(MSG_WORDS) : 1;
   localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);
   localparam logic [SW-1:0] POS_LAST = SW'(MSG_WORDS - 1);

   logic [W-1:0]  mem_q [FIFO_DEPTH];
   logic [W-1:0]  mem_d [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic [SW-1:0] pos_q, pos_d;
   logic [W-1:0]  data_q, data_d;
   logic          valid_q, valid_d;
   logic          sof_q, sof_d;

   logic          in_ready;
   logic          push;
   logic          pop;
   logic          wr;
   logic          bypass;
   logic [SW-1:0] pos_next;

   // A full FIFO refuses input even when a pop happens in the same cycle,
   // which keeps in_ready free of any dependency on enc_stall.
   assign in_ready = rst_n && !bus.flush && (level_q < LVL_FULL);
   assign push     = bus.in_valid && in_ready;
   assign pop      = !bus.flush && !bus.enc_stall && (level_q != '0);

`ifdef ENC_FEEDER_BYPASS_EN
   assign bypass   = push && !bus.enc_stall && (level_q == '0);
`else
   assign bypass   = 1'b0;
`endif

   // A bypassed word never occupies a FIFO slot.
   assign wr       = push && !bypass;
   assign pos_next = (pos_q == POS_LAST) ? '0 : pos_q + SW'(1);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      pos_d    = pos_q;
      data_d   = data_q;
      valid_d  = valid_q;
      sof_d    = sof_q;

      if (bus.flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
         pos_d    = '0;
         data_d   = '0;
         valid_d  = 1'b0;
         sof_d    = 1'b0;
      end else begin
         if (wr) begin
            mem_d[wr_ptr_q] = bus.in_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
         end

         if (!bus.enc_stall) begin
            if (pop) begin
               data_d   = mem_q[rd_ptr_q];
               valid_d  = 1'b1;
               sof_d    = (pos_q == '0);
               pos_d    = pos_next;
               rd_ptr_d = rd_ptr_q + PW'(1);
            end else if (bypass) begin
               data_d  = bus.in_data;
               valid_d = 1'b1;
               sof_d   = (pos_q == '0);
               pos_d   = pos_next;
            end else begin
               // Bubble: no word, and the codeword position does not move.
               data_d  = '0;
               valid_d = 1'b0;
               sof_d   = 1'b0;
            end
         end

         if (wr && !pop) begin
            level_d = level_q + LW'(1);
         end else if (!wr && pop) begin
            level_d = level_q - LW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         pos_q    <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         sof_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         pos_q    <= pos_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         sof_q    <= sof_d;
      end
   end

   // Storage needs no reset; pointers and level decide what is valid.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign bus.in_ready  = in_ready;
   assign bus.data_out  = data_q;
   assign bus.out_valid = valid_q;
   assign bus.out_sof   = sof_q;
   assign bus.level     = level_q;
endmodule

// File: tb/tb_enc_feeder.sv
// tb_enc_feeder: checks enc_feeder (4 symbols x 8 bits, 4-deep FIFO,
// 3 message words per codeword) against a queue-based reference model.
module tb_enc_feeder;
   localparam int EGF_ORDER   = 8;
   localparam int ENC_SYM_NUM = 4;
   localparam int FIFO_DEPTH  = 4;
   localparam int MSG_WORDS   = 3;
   localparam int W           = ENC_SYM_NUM * EGF_ORDER;
   localparam int LW          = $clog2(FIFO_DEPTH + 1);
`ifdef ENC_FEEDER_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk;
   logic rst_n;

   enc_feeder_if #(.W(W), .LW(LW)) bus ();

   enc_feeder #(
      .EGF_ORDER  (EGF_ORDER),
      .ENC_SYM_NUM(ENC_SYM_NUM),
      .FIFO_DEPTH (FIFO_DEPTH),
      .MSG_WORDS  (MSG_WORDS)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: the buffer is just an ordered queue of accepted words.
   logic [W-1:0] mq[$];
   int           mpos;
   logic [W-1:0] m_data;
   logic         m_valid;
   logic         m_sof;
   logic         rdy_seen;
   logic         rdy_exp;

   task automatic model_reset();
      mq.delete();
      mpos    = 0;
      m_data  = '0;
      m_valid = 1'b0;
      m_sof   = 1'b0;
   endtask

   task automatic model_edge(input logic v, input logic [W-1:0] d,
                             input logic st, input logic fl, input logic acc);
      logic direct;
      direct = BYP && acc && !st && (mq.size() == 0);
      if (fl) begin
         model_reset();
      end else begin
         if (!st) begin
            if (mq.size() > 0) begin
               m_data  = mq.pop_front();
               m_valid = 1'b1;
               m_sof   = (mpos == 0);
               mpos    = (mpos + 1) % MSG_WORDS;
            end else if (direct) begin
               m_data  = d;
               m_valid = 1'b1;
               m_sof   = (mpos == 0);
               mpos    = (mpos + 1) % MSG_WORDS;
            end else begin
               m_data  = '0;
               m_valid = 1'b0;
               m_sof   = 1'b0;
            end
         end
         if (acc && !direct) mq.push_back(d);
      end
   endtask

   // One clock: drive at the falling edge, sample ready before the rising
   // edge, advance the model at the rising edge, return at the next falling
   // edge where outputs are compared.
   task automatic cycle(input logic v, input logic [W-1:0] d, input logic st,
                        input logic fl, output logic acc);
      bus.in_valid  = v;
      bus.in_data   = d;
      bus.enc_stall = st;
      bus.flush     = fl;
      #1;
      rdy_seen = bus.in_ready;
      rdy_exp  = !fl && (mq.size() < FIFO_DEPTH);
      acc      = v && rdy_exp;
      @(posedge clk);
      model_edge(v, d, st, fl, acc);
      @(negedge clk);
   endtask

   function automatic logic [W+LW+2:0] obs();
      return {bus.data_out, bus.out_valid, bus.out_sof, bus.level, rdy_seen};
   endfunction

   function automatic logic [W+LW+2:0] expv();
      return {m_data, m_valid, m_sof, LW'(mq.size()), rdy_exp};
   endfunction

   task automatic test_reset();
      rst_n         = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_data   = 32'hDEADBEEF;
      bus.enc_stall = 1'b0;
      bus.flush     = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_cmp++;
      if (bus.data_out !== '0) begin
         n_err++; $display("FAIL reset.data_out got %h want 0", bus.data_out);
      end
      n_cmp++;
      if ({bus.out_valid, bus.out_sof} !== 2'b00) begin
         n_err++; $display("FAIL reset.valid_sof got %b want 00", {bus.out_valid, bus.out_sof});
      end
      n_cmp++;
      if (bus.level !== '0) begin
         n_err++; $display("FAIL reset.level got %0d want 0", bus.level);
      end
      n_cmp++;
      if (bus.in_ready !== 1'b0) begin
         n_err++; $display("FAIL reset.in_ready got %b want 0", bus.in_ready);
      end
      bus.in_valid = 1'b0;
      rst_n        = 1'b1;
      model_reset();
   endtask

   task automatic test_stream();
      logic [W-1:0] w[$];
      logic [W-1:0] sofs[$];
      logic acc;
      int i = 0;
      for (int k = 0; k < 6; k++) w.push_back(32'h11111111 * (k + 1));
      for (int c = 0; c < 12; c++) begin
         if (i < 6) cycle(1'b1, w[i], 1'b0, 1'b0, acc);
         else       cycle(1'b0, '0, 1'b0, 1'b0, acc);
         if (acc) i++;
         if (bus.out_valid && bus.out_sof) sofs.push_back(bus.data_out);
         n_cmp++;
         if (obs() !== expv()) begin
            n_err++; $display("FAIL stream c%0d got %h want %h", c, obs(), expv());
         end
      end
      n_cmp++;
      if (sofs.size() != 2 || sofs[0] !== 32'h11111111 || sofs[1] !== 32'h44444444) begin
         n_err++;
         $display("FAIL stream.sof_words got %0d words (%h %h) want 2 (11111111 44444444)",
                  sofs.size(), (sofs.size() > 0) ? sofs[0] : '0, (sofs.size() > 1) ? sofs[1] : '0);
      end
   endtask

   task automatic test_stall_full();
      logic [W-1:0] w[5];
      logic acc;
      int i = 0;
      int first_rdy = -1;
      for (int k = 0; k < 5; k++) w[k] = $urandom | 32'h1;
      for (int c = 0; c < 5; c++) begin
         cycle(1'b1, w[i], 1'b1, 1'b0, acc);
         if (acc) i++;
         n_cmp++;
         if (obs() !== expv()) begin
            n_err++; $display("FAIL stall_full.fill c%0d got %h want %h", c, obs(), expv());
         end
      end
      n_cmp++;
      if (bus.level !== 3'd4 || rdy_seen !== 1'b0) begin
         n_err++; $display("FAIL stall_full.full got level=%0d rdy=%b want level=4 rdy=0", bus.level, rdy_seen);
      end
      for (int r = 0; r < 10; r++) begin
         if (i < 5) cycle(1'b1, w[i], 1'b0, 1'b0, acc);
         else       cycle(1'b0, '0, 1'b0, 1'b0, acc);
         if (i == 4 && rdy_seen && first_rdy < 0) first_rdy = r;
         if (acc) i++;
         n_cmp++;
         if (obs() !== expv()) begin
            n_err++; $display("FAIL stall_full.drain r%0d got %h want %h", r, obs(), expv());
         end
      end
      n_cmp++;
      if (first_rdy != 1) begin
         n_err++; $display("FAIL stall_full.fifth_accept got cycle %0d want 1", first_rdy);
      end
   endtask

   task automatic test_toggle();
      logic acc;
      int i = 0;
      logic [W-1:0] w;
      w = $urandom | 32'h1;
      for (int c = 0; c < 20; c++) begin
         if (i < 6) cycle(1'b1, w, (c % 2) == 0, 1'b0, acc);
         else       cycle(1'b0, '0, (c % 2) == 0, 1'b0, acc);
         if (acc) begin i++; w = $urandom | 32'h1; end
         n_cmp++;
         if (obs() !== expv()) begin
            n_err++; $display("FAIL toggle c%0d got %h want %h", c, obs(), expv());
         end
      end
   endtask

   task automatic test_gaps();
      logic acc;
      for (int k = 0; k < 5; k++) begin
         for (int g = 0; g < 3; g++) begin
            if (g == 0) cycle(1'b1, $urandom | 32'h1, 1'b0, 1'b0, acc);
            else        cycle(1'b0, '0, 1'b0, 1'b0, acc);
            n_cmp++;
            if (obs() !== expv()) begin
               n_err++; $display("FAIL gaps k%0d g%0d got %h want %h", k, g, obs(), expv());
            end
         end
      end
   endtask

   task automatic test_flush();
      logic acc;
      logic seen_sof = 1'b0;
      cycle(1'b0, '0, 1'b0, 1'b1, acc);
      cycle(1'b1, 32'h01010101, 1'b0, 1'b0, acc);
      cycle(1'b1, 32'h02020202, 1'b0, 1'b0, acc);
      cycle(1'b0, '0, 1'b0, 1'b0, acc);
      for (int k = 0; k < 3; k++) cycle(1'b1, 32'h03030303 + k, 1'b1, 1'b0, acc);
      n_cmp++;
      if (bus.level !== 3'd3 || mpos != 2) begin
         n_err++; $display("FAIL flush.setup got level=%0d pos=%0d want level=3 pos=2", bus.level, mpos);
      end
      cycle(1'b1, 32'hBBBBBBBB, 1'b1, 1'b1, acc);
      n_cmp++;
      if (bus.level !== '0 || bus.out_valid !== 1'b0 || bus.data_out !== '0) begin
         n_err++; $display("FAIL flush.clear got level=%0d valid=%b data=%h want 0/0/0",
                           bus.level, bus.out_valid, bus.data_out);
      end
      cycle(1'b1, 32'hAAAAAAAA, 1'b0, 1'b0, acc);
      if (bus.out_valid && bus.data_out === 32'hAAAAAAAA && bus.out_sof) seen_sof = 1'b1;
      n_cmp++;
      if (obs() !== expv()) begin
         n_err++; $display("FAIL flush.push got %h want %h", obs(), expv());
      end
      cycle(1'b0, '0, 1'b0, 1'b0, acc);
      if (bus.out_valid && bus.data_out === 32'hAAAAAAAA && bus.out_sof) seen_sof = 1'b1;
      n_cmp++;
      if (seen_sof !== 1'b1) begin
         n_err++; $display("FAIL flush.sof got %b want 1", seen_sof);
      end
   endtask

   task automatic test_async_reset();
      logic acc;
      for (int k = 0; k < 3; k++) cycle(1'b1, $urandom | 32'h1, 1'b0, 1'b0, acc);
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (bus.data_out !== '0 || bus.level !== '0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
         n_err++; $display("FAIL async_reset got data=%h level=%0d valid=%b rdy=%b want 0/0/0/0",
                           bus.data_out, bus.level, bus.out_valid, bus.in_ready);
      end
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      cycle(1'b1, 32'h5A5A5A5A, 1'b0, 1'b0, acc);
      n_cmp++;
      if (BYP) begin
         if (bus.data_out !== 32'h5A5A5A5A || bus.out_sof !== 1'b1 || bus.level !== '0) begin
            n_err++; $display("FAIL async_reset.bypass got data=%h sof=%b level=%0d want 5a5a5a5a/1/0",
                              bus.data_out, bus.out_sof, bus.level);
         end
      end else begin
         if (bus.out_valid !== 1'b0 || bus.level !== 3'd1) begin
            n_err++; $display("FAIL async_reset.push got valid=%b level=%0d want 0/1", bus.out_valid, bus.level);
         end
      end
      cycle(1'b0, '0, 1'b0, 1'b0, acc);
      n_cmp++;
      if (obs() !== expv()) begin
         n_err++; $display("FAIL async_reset.after got %h want %h", obs(), expv());
      end
   endtask

   task automatic test_random();
      logic acc;
      for (int c = 0; c < 400; c++) begin
         cycle($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) == 0,
               $urandom_range(0, 40) == 0, acc);
         n_cmp++;
         if (obs() !== expv()) begin
            n_err++; $display("FAIL random c%0d got %h want %h", c, obs(), expv());
         end
      end
   endtask

   initial begin
      model_reset();
      rdy_seen = 1'b0;
      rdy_exp  = 1'b0;
      test_reset();
      test_stream();
      test_stall_full();
      test_toggle();
      test_gaps();
      test_flush();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
